// File: rtl/cgra_config_readback.sv
// Readback checker for the CGRA configuration scan chain: it clocks the chain out once and
// accumulates a bit-serial CRC-32 and a bit count. Optional: CONFIG_READBACK_RECIRCULATE_EN.
module cgra_config_readback #(
   parameter int unsigned BITSTREAM_LEN = 4096,
   parameter logic [31:0] EXPECTED_CRC  = 32'h0000_0000,
   localparam int unsigned CNT_W        = $clog2(BITSTREAM_LEN + 1)
) (
   input  logic             clock,
   input  logic             sync_reset,
   input  logic             start,
   input  logic             config_out_bit,
   output logic             config_clock_en,
   output logic             config_in_bit,
   output logic             busy,
   output logic             done,
   output logic             pass,
   output logic [31:0]      crc_value,
   output logic [CNT_W-1:0] bit_count
);

   localparam logic [31:0]      CRC_POLY = 32'h04C1_1DB7;
   localparam logic [31:0]      CRC_SEED = '1;
   localparam logic [CNT_W-1:0] LEN_C    = CNT_W'(BITSTREAM_LEN);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_SHIFT,
      ST_CHECK,
      ST_DONE
   } state_t;

   state_t           state, state_nxt;
   logic [31:0]      crc_nxt;
   logic [31:0]      crc_shift;
   logic             crc_fb;
   logic [CNT_W-1:0] cnt_nxt;
   logic             en_nxt;
   logic             pass_nxt;

   always_ff @(posedge clock) begin
      if (sync_reset) begin
         state           <= ST_IDLE;
         crc_value       <= CRC_SEED;
         bit_count       <= '0;
         config_clock_en <= 1'b0;
         pass            <= 1'b0;
      end else begin
         state           <= state_nxt;
         crc_value       <= crc_nxt;
         bit_count       <= cnt_nxt;
         config_clock_en <= en_nxt;
         pass            <= pass_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      crc_nxt   = crc_value;
      cnt_nxt   = bit_count;
      en_nxt    = config_clock_en;
      pass_nxt  = pass;
      crc_fb    = crc_value[31] ^ config_out_bit;
      crc_shift = {crc_value[30:0], 1'b0} ^ (crc_fb ? CRC_POLY : '0);

      case (state)
         ST_IDLE, ST_DONE: begin
            if (start) begin
               state_nxt = ST_SHIFT;
               crc_nxt   = CRC_SEED;
               cnt_nxt   = '0;
               en_nxt    = 1'b1;
               pass_nxt  = 1'b0;
            end
         end
         ST_SHIFT: begin
            // The enable drops on the same edge that takes the last bit, so the chain
            // sees exactly BITSTREAM_LEN gated edges.
            crc_nxt = crc_shift;
            if (bit_count != LEN_C) cnt_nxt = bit_count + CNT_ONE;
            if (cnt_nxt == LEN_C) begin
               state_nxt = ST_CHECK;
               en_nxt    = 1'b0;
            end
         end
         ST_CHECK: begin
            state_nxt = ST_DONE;
            pass_nxt  = (crc_value == EXPECTED_CRC) && (bit_count == LEN_C);
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   assign busy = (state == ST_SHIFT) || (state == ST_CHECK);
   assign done = (state == ST_DONE);

`ifdef CONFIG_READBACK_RECIRCULATE_EN
   assign config_in_bit = (state == ST_SHIFT) ? config_out_bit : 1'b0;
`else
   assign config_in_bit = 1'b0;
`endif

endmodule

// File: tb/tb_cgra_config_readback.sv
// Directed bench for cgra_config_readback: LEN=1 CRC/pass vectors and a 64-bit chain model.
module tb_cgra_config_readback;

   localparam logic [63:0] PATTERN = 64'hA5C3_9E17_0F2B_D468;

   function automatic logic [31:0] crc_model(input logic [63:0] data, input int n);
      logic [31:0] c;
      logic        fb;
      c = 32'hFFFF_FFFF;
      for (int i = n - 1; i >= 0; i--) begin
         fb = c[31] ^ data[i];
         c  = (c << 1) ^ (fb ? 32'h04C1_1DB7 : 32'h0000_0000);
      end
      return c;
   endfunction

   localparam logic [31:0] EXP64 = crc_model(PATTERN, 64);

`ifdef CONFIG_READBACK_RECIRCULATE_EN
   localparam logic [63:0] CHAIN_AFTER = PATTERN;
`else
   localparam logic [63:0] CHAIN_AFTER = 64'h0;
`endif

   logic clock = 1'b0;
   always #5 clock = ~clock;

   logic sync_reset, start1, start64, load1, load64;
   int   checks = 0;
   int   errors = 0;
   int   en_cnt = 0;
   int   cycles;
   logic inv_bad = 1'b0;

   logic       en_a, in_a, busy_a, done_a, pass_a, chain_a;
   logic       en_b, in_b, busy_b, done_b, pass_b, chain_b;
   logic       en_c, in_c, busy_c, done_c, pass_c, chain_c;
   logic [31:0] crc_a, crc_b, crc_c, crc_64;
   logic [0:0] cnt_a, cnt_b, cnt_c;
   logic       en_64, in_64, busy_64, done_64, pass_64;
   logic [6:0] cnt_64;
   logic [63:0] chain64;

   cgra_config_readback #(.BITSTREAM_LEN(1), .EXPECTED_CRC(32'hFFFF_FFFE)) u_a (
      .clock(clock), .sync_reset(sync_reset), .start(start1), .config_out_bit(chain_a),
      .config_clock_en(en_a), .config_in_bit(in_a), .busy(busy_a), .done(done_a),
      .pass(pass_a), .crc_value(crc_a), .bit_count(cnt_a));

   cgra_config_readback #(.BITSTREAM_LEN(1), .EXPECTED_CRC(32'hFB3E_E249)) u_b (
      .clock(clock), .sync_reset(sync_reset), .start(start1), .config_out_bit(chain_b),
      .config_clock_en(en_b), .config_in_bit(in_b), .busy(busy_b), .done(done_b),
      .pass(pass_b), .crc_value(crc_b), .bit_count(cnt_b));

   cgra_config_readback #(.BITSTREAM_LEN(1), .EXPECTED_CRC(32'h0000_0000)) u_c (
      .clock(clock), .sync_reset(sync_reset), .start(start1), .config_out_bit(chain_c),
      .config_clock_en(en_c), .config_in_bit(in_c), .busy(busy_c), .done(done_c),
      .pass(pass_c), .crc_value(crc_c), .bit_count(cnt_c));

   cgra_config_readback #(.BITSTREAM_LEN(64), .EXPECTED_CRC(EXP64)) u_64 (
      .clock(clock), .sync_reset(sync_reset), .start(start64), .config_out_bit(chain64[63]),
      .config_clock_en(en_64), .config_in_bit(in_64), .busy(busy_64), .done(done_64),
      .pass(pass_64), .crc_value(crc_64), .bit_count(cnt_64));

   // Chain models shift only on gated edges (ideal clock gate).
   always @(posedge clock) begin
      if (load1) begin
         chain_a <= 1'b1;
         chain_b <= 1'b1;
         chain_c <= 1'b0;
      end else begin
         if (en_a) chain_a <= in_a;
         if (en_b) chain_b <= in_b;
         if (en_c) chain_c <= in_c;
      end
      if (load64)     chain64 <= PATTERN;
      else if (en_64) chain64 <= {chain64[62:0], in_64};
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clock);
      #1;
      if (en_64 === 1'b1) en_cnt++;
      if ((en_64 && !busy_64) || (done_64 && busy_64) || (pass_64 && !done_64)) inv_bad = 1'b1;
   endtask

   task automatic wait_done64(output int n);
      n = 0;
      while (done_64 !== 1'b1 && n < 200) begin
         step();
         n++;
      end
      check("done64_within_bound", 32'(done_64), 32'd1);
   endtask

   task automatic run64(input string tag);
      load64 = 1'b1;
      step();
      load64 = 1'b0;
      start64 = 1'b1;
      en_cnt = 0;
      step();
      start64 = 1'b0;
      wait_done64(cycles);
      check({tag, "_latency"}, 32'(cycles), 32'd65);
      check({tag, "_en_cycles"}, 32'(en_cnt), 32'd64);
      check({tag, "_crc"}, crc_64, EXP64);
      check({tag, "_count"}, 32'(cnt_64), 32'd64);
      check({tag, "_pass"}, 32'(pass_64), 32'd1);
   endtask

   task automatic check_reset64(input string tag);
      check({tag, "_en"}, 32'(en_64), 32'd0);
      check({tag, "_in"}, 32'(in_64), 32'd0);
      check({tag, "_busy"}, 32'(busy_64), 32'd0);
      check({tag, "_done"}, 32'(done_64), 32'd0);
      check({tag, "_pass"}, 32'(pass_64), 32'd0);
      check({tag, "_crc"}, crc_64, 32'hFFFF_FFFF);
      check({tag, "_count"}, 32'(cnt_64), 32'd0);
   endtask

   initial begin
      sync_reset = 1'b1;
      start1 = 1'b0;
      start64 = 1'b0;
      load1 = 1'b1;
      load64 = 1'b1;
      repeat (3) step();
      sync_reset = 1'b0;
      load1 = 1'b0;
      load64 = 1'b0;
      check_reset64("rst64");
      check("rst1_crc", crc_c, 32'hFFFF_FFFF);
      check("rst1_done", 32'(done_c), 32'd0);

      // LEN=1 vectors
      start1 = 1'b1;
      step();
      start1 = 1'b0;
      check("len1_en_c0", 32'(en_c), 32'd1);
      check("len1_busy_c0", 32'(busy_c), 32'd1);
      step();
      check("len1_en_c1", 32'(en_c), 32'd0);
      check("len1_check_busy", 32'(busy_c), 32'd1);
      check("len1_check_done", 32'(done_c), 32'd0);
      check("len1_crc_bit0", crc_c, 32'hFB3E_E249);
      check("len1_count", 32'(cnt_c), 32'd1);
      check("len1_crc_bit1", crc_a, 32'hFFFF_FFFE);
      step();
      check("len1_done", 32'(done_c), 32'd1);
      check("len1_busy_done", 32'(busy_c), 32'd0);
      check("len1_pass_match", 32'(pass_a), 32'd1);
      check("len1_pass_mismatch", 32'(pass_b), 32'd0);
      check("len1_pass_c", 32'(pass_c), 32'd0);

      // LEN=64 full readback
      run64("full");
      check("full_busy", 32'(busy_64), 32'd0);
      check("full_chain_after", chain64[31:0], CHAIN_AFTER[31:0]);
      check("full_chain_after_hi", chain64[63:32], CHAIN_AFTER[63:32]);

      // Reset during SHIFT cycle 10
      load64 = 1'b1;
      step();
      load64 = 1'b0;
      start64 = 1'b1;
      step();
      start64 = 1'b0;
      repeat (9) step();
      check("abort_count_before", 32'(cnt_64), 32'd9);
      sync_reset = 1'b1;
      step();
      sync_reset = 1'b0;
      check_reset64("abort");
      run64("restart");

      // start during SHIFT and CHECK is ignored
      load64 = 1'b1;
      step();
      load64 = 1'b0;
      start64 = 1'b1;
      en_cnt = 0;
      step();
      start64 = 1'b0;
      repeat (4) step();
      start64 = 1'b1;
      step();
      start64 = 1'b0;
      repeat (59) step();
      check("ign_check_busy", 32'(busy_64), 32'd1);
      check("ign_check_en", 32'(en_64), 32'd0);
      start64 = 1'b1;
      step();
      start64 = 1'b0;
      check("ign_done", 32'(done_64), 32'd1);
      check("ign_en_cycles", 32'(en_cnt), 32'd64);
      check("ign_crc", crc_64, EXP64);
      step();
      check("ign_done_held", 32'(done_64), 32'd1);

      // start in DONE restarts; identical CRC on reloaded chain
      load64 = 1'b1;
      step();
      load64 = 1'b0;
      start64 = 1'b1;
      en_cnt = 0;
      step();
      start64 = 1'b0;
      check("redo_done_drop", 32'(done_64), 32'd0);
      check("redo_busy", 32'(busy_64), 32'd1);
      check("redo_crc_seed", crc_64, 32'hFFFF_FFFF);
      check("redo_pass_clr", 32'(pass_64), 32'd0);
      wait_done64(cycles);
      check("redo_crc_same", crc_64, EXP64);
      check("redo_en_cycles", 32'(en_cnt), 32'd64);
      check("redo_pass", 32'(pass_64), 32'd1);

      check("invariants", 32'(inv_bad), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
